// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mul_div_unit
//  Purpose  : Iterative WIDTH-bit multiply / divide unit placed after the
//             register file. Computes MUL (low half), UDIV or SDIV over a
//             fixed latency and issues a one-cycle write-back request.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk     in   rising-edge clock
//    rst_n   in   asynchronous active-low reset
//    start   in   request, sampled only while idle
//    op      in   00 MUL, 01 UDIV, 10 SDIV, 11 reserved (result 0)
//    a       in   operand 1 (multiplicand / dividend)
//    b       in   operand 2 (multiplier / divisor)
//    rd_in   in   destination register index
//    busy    out  high from accept until the done cycle ends
//    done    out  one-cycle completion pulse
//    result  out  computed value, held until overwritten by the next op
//    wr_rd   out  latched destination index
//    wr_en   out  write-back strobe, suppressed for register 31 (XZR)
// ============================================================================
module mul_div_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       wr_rd,
    output logic             wr_en
);

    localparam int         CNT_W     = $clog2(WIDTH);
    localparam logic [1:0] c_OP_MUL  = 2'b00;
    localparam logic [1:0] c_OP_UDIV = 2'b01;
    localparam logic [1:0] c_OP_SDIV = 2'b10;
    localparam logic [4:0] c_XZR     = 5'd31;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_x;      // multiplier (shifts right) / dividend (shifts left)
    logic [WIDTH-1:0]   r_y;      // multiplicand (shifts left) / divisor (fixed)
    logic [WIDTH-1:0]   r_acc;    // product accumulator / quotient
    logic [WIDTH-1:0]   r_rem;    // partial remainder (always < divisor)
    logic [CNT_W-1:0]   r_cnt;
    logic               r_prep;   // first RUN cycle: operand conditioning
    logic               r_neg;
    logic               r_dz;

    logic [WIDTH-1:0]   w_x_nxt;
    logic [WIDTH-1:0]   w_y_nxt;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH:0]     w_rem_sh;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_final;
    logic [WIDTH-1:0]   w_x_abs;
    logic [WIDTH-1:0]   w_y_abs;

    assign w_x_abs = r_x[WIDTH-1] ? -r_x : r_x;
    assign w_y_abs = r_y[WIDTH-1] ? -r_y : r_y;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. RUN lasts WIDTH+1 cycles: one conditioning cycle
    // followed by WIDTH iterations counted down from WIDTH-1 to 0.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (!r_prep && (r_cnt == '0)) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // One iteration of the selected algorithm
    // ------------------------------------------------------------------
    always_comb begin
        w_rem_sh  = {r_rem, r_x[WIDTH-1]};
        w_diff    = w_rem_sh - {1'b0, r_y};
        w_acc_nxt = r_acc;
        w_x_nxt   = r_x;
        w_y_nxt   = r_y;
        w_rem_nxt = r_rem;
        w_final   = '0;

        if ((r_op == c_OP_UDIV) || (r_op == c_OP_SDIV)) begin
            // Restoring divide: a clear borrow bit means the trial fits.
            w_x_nxt = r_x << 1;
            if (!w_diff[WIDTH]) begin
                w_rem_nxt = w_diff[WIDTH-1:0];
                w_acc_nxt = {r_acc[WIDTH-2:0], 1'b1};
            end else begin
                w_rem_nxt = w_rem_sh[WIDTH-1:0];
                w_acc_nxt = {r_acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Shift-add multiply, multiplier LSB first
            if (r_x[0]) begin
                w_acc_nxt = r_acc + r_y;
            end
            w_y_nxt = r_y << 1;
            w_x_nxt = r_x >> 1;
        end

        // Most-negative / -1 yields magnitude 2^(WIDTH-1) with equal signs,
        // so the overflow case wraps to the required value without help.
        case (r_op)
            c_OP_MUL:  w_final = w_acc_nxt;
            c_OP_UDIV: w_final = r_dz ? '0 : w_acc_nxt;
            c_OP_SDIV: w_final = r_dz ? '0 : (r_neg ? -w_acc_nxt : w_acc_nxt);
            default:   w_final = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op   <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_acc  <= '0;
            r_rem  <= '0;
            r_cnt  <= '0;
            r_prep <= 1'b0;
            r_neg  <= 1'b0;
            r_dz   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            wr_en  <= 1'b0;
            result <= '0;
            wr_rd  <= '0;
        end else begin
            busy  <= (w_state_nxt != S_IDLE);
            done  <= (w_state_nxt == S_DONE);
            wr_en <= (w_state_nxt == S_DONE) && (wr_rd != c_XZR);

            if ((r_state == S_IDLE) && start) begin
                r_op   <= op;
                r_x    <= a;
                r_y    <= b;
                wr_rd  <= rd_in;
                r_acc  <= '0;
                r_rem  <= '0;
                r_cnt  <= CNT_W'(WIDTH - 1);
                r_prep <= 1'b1;
            end else if (r_state == S_RUN) begin
                if (r_prep) begin
                    r_prep <= 1'b0;
                    r_dz   <= (r_y == '0);
                    r_neg  <= r_x[WIDTH-1] ^ r_y[WIDTH-1];
                    if (r_op == c_OP_SDIV) begin
                        r_x <= w_x_abs;
                        r_y <= w_y_abs;
                    end
                end else begin
                    r_x   <= w_x_nxt;
                    r_y   <= w_y_nxt;
                    r_acc <= w_acc_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        result <= w_final;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mul_div_unit
//  Purpose  : Self-checking bench for mul_div_unit. A cycle-level reference
//             model built from plain arithmetic predicts every output each
//             cycle; directed cases pin the model against literal values.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mul_div_unit;

    localparam int          WIDTH = 64;
    localparam logic [63:0] c_MIN = 64'h8000_0000_0000_0000;
    localparam logic [1:0]  c_MUL = 2'b00;
    localparam logic [1:0]  c_UDV = 2'b01;
    localparam logic [1:0]  c_SDV = 2'b10;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op    = '0;
    logic [63:0] a     = '0;
    logic [63:0] b     = '0;
    logic [4:0]  rd_in = '0;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  wr_rd;
    logic        wr_en;

    int n_checks = 0;
    int n_fail   = 0;

    mul_div_unit #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wr_rd  (wr_rd),
        .wr_en  (wr_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic reference, straight from the operation definitions
    function automatic logic [63:0] ref_calc(input logic [1:0] f_op, input logic [63:0] fa,
                                             input logic [63:0] fb);
        longint sa;
        longint sb;
        sa = fa;
        sb = fb;
        case (f_op)
            2'b00: return fa * fb;
            2'b01: return (fb == 0) ? 64'd0 : fa / fb;
            2'b10: begin
                if (fb == 0) return 64'd0;
                if (fa == c_MIN && fb == '1) return c_MIN;
                return 64'(sa / sb);
            end
            default: return 64'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Cycle-level expectation: accept when idle, done WIDTH+1 edges later,
    // idle again on the following edge.
    // ------------------------------------------------------------------
    logic        m_busy, m_done, m_wren;
    logic [63:0] m_result, m_pend;
    logic [4:0]  m_rd;
    int          m_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_wren <= 1'b0;
            m_result <= '0; m_pend <= '0; m_rd <= '0; m_t <= 0;
        end else if (!m_busy) begin
            if (start) begin
                m_busy <= 1'b1;
                m_t    <= 0;
                m_pend <= ref_calc(op, a, b);
                m_rd   <= rd_in;
            end
        end else if (m_done) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_wren <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            if (m_t + 1 == WIDTH + 1) begin
                m_done   <= 1'b1;
                m_wren   <= (m_rd != 5'd31);
                m_result <= m_pend;
            end
        end
    end

    always @(negedge clk) begin
        check("busy",   {63'd0, busy},  {63'd0, m_busy});
        check("done",   {63'd0, done},  {63'd0, m_done});
        check("wr_en",  {63'd0, wr_en}, {63'd0, m_wren});
        check("wr_rd",  {59'd0, wr_rd}, {59'd0, m_rd});
        check("result", result, m_result);
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at a negedge, return at a negedge)
    // ------------------------------------------------------------------
    task automatic issue(input logic [1:0] t_op, input logic [63:0] ta, input logic [63:0] tb,
                         input logic [4:0] trd);
        int g;
        g = 0;
        while (busy && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy) check("idle_timeout", 64'd1, 64'd0);
        start = 1'b1; op = t_op; a = ta; b = tb; rd_in = trd;
        @(negedge clk);
        // Scramble operands after accept; they must not matter any more
        start = 1'b0; op = 2'($urandom); a = {$urandom, $urandom};
        b = {$urandom, $urandom}; rd_in = 5'($urandom);
    endtask

    task automatic wait_done(output int lat, output logic [63:0] res, output logic wen,
                             output logic [4:0] wrd);
        int k;
        k = 1;
        while (!done && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!done) check("done_timeout", 64'd1, 64'd0);
        lat = k - 1; res = result; wen = wr_en; wrd = wr_rd;
        @(negedge clk);
    endtask

    task automatic run_lit(input string name, input logic [1:0] t_op, input logic [63:0] ta,
                           input logic [63:0] tb, input logic [4:0] trd,
                           input logic [63:0] exp_res, input logic exp_wen);
        int          lat;
        logic [63:0] res;
        logic        wen;
        logic [4:0]  wrd;
        check({name, "_model"}, ref_calc(t_op, ta, tb), exp_res);
        issue(t_op, ta, tb, trd);
        wait_done(lat, res, wen, wrd);
        check({name, "_latency"}, 64'(lat), 64'd65);
        check({name, "_result"}, res, exp_res);
        check({name, "_wr_en"}, {63'd0, wen}, {63'd0, exp_wen});
        check({name, "_wr_rd"}, {59'd0, wrd}, {59'd0, trd});
    endtask

    initial begin
        int          lat;
        int          k;
        int          seen;
        logic [63:0] res;
        logic        wen;
        logic [4:0]  wrd;
        logic [63:0] ra, rb;
        logic [1:0]  rop;

        repeat (3) @(negedge clk);
        check("reset_busy",   {63'd0, busy}, 64'd0);
        check("reset_result", result, 64'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_lit("mul_7x-3", c_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd4,
                64'hFFFF_FFFF_FFFF_FFEB, 1'b1);
        run_lit("udiv_100_7", c_UDV, 64'd100, 64'd7, 5'd2, 64'd14, 1'b1);
        run_lit("sdiv_-100_7", c_SDV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd3,
                64'hFFFF_FFFF_FFFF_FFF2, 1'b1);
        run_lit("udiv_by0", c_UDV, 64'd55, 64'd0, 5'd5, 64'd0, 1'b1);
        run_lit("sdiv_by0", c_SDV, 64'd55, 64'd0, 5'd6, 64'd0, 1'b1);
        run_lit("sdiv_ovf", c_SDV, c_MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd7, c_MIN, 1'b1);
        run_lit("mul_xzr", c_MUL, 64'd3, 64'd5, 5'd31, 64'd15, 1'b0);
        run_lit("reserved", 2'b11, 64'd9, 64'd9, 5'd8, 64'd0, 1'b1);

        // Start pulses inside RUN and in the DONE cycle are ignored
        issue(c_UDV, 64'd1000, 64'd7, 5'd9);
        k = 1;
        while (!done && k < 200) begin
            start = (k == 10 || k == 65);
            if (start) begin op = c_SDV; a = {$urandom, $urandom}; b = 64'd3; end
            @(negedge clk);
            k++;
        end
        if (!done) check("ign_timeout", 64'd1, 64'd0);
        check("ign_latency", 64'(k - 1), 64'd65);
        check("ign_result", result, 64'd142);
        start = 1'b1; op = c_SDV; b = 64'd3;
        @(negedge clk);
        start = 1'b0;
        check("ign_idle_after", {63'd0, busy}, 64'd0);
        run_lit("mul_6x7", c_MUL, 64'd6, 64'd7, 5'd10, 64'd42, 1'b1);

        // Reset in the middle of an SDIV
        issue(c_SDV, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd11);
        repeat (29) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy",   {63'd0, busy},  64'd0);
        check("rst_done",   {63'd0, done},  64'd0);
        check("rst_wr_en",  {63'd0, wr_en}, 64'd0);
        check("rst_result", result, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || wr_en) seen++;
        end
        check("rst_no_writeback", 64'(seen), 64'd0);
        run_lit("mul_2x2", c_MUL, 64'd2, 64'd2, 5'd12, 64'd4, 1'b1);

        // Randomized operations with corner operands mixed in
        for (int i = 0; i < 30; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            case ($urandom_range(0, 6))
                0: rb = 64'd0;
                1: begin ra = c_MIN; rb = '1; end
                2: rb = 64'($urandom_range(1, 20));
                3: rb = -64'($urandom_range(1, 20));
                4: ra = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            issue(rop, ra, rb, 5'($urandom_range(0, 31)));
            wait_done(lat, res, wen, wrd);
            check("rand_latency", 64'(lat), 64'd65);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
